// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and bus width limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Widest data and address buses an APB segment is allowed to carry.
    localparam int APB_MAX_DW = 32;
    localparam int APB_MAX_AW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request searching upward from ptr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
//
// Ports:
//   req  [NREQ-1:0]  request vector
//   ptr  [IW-1:0]    index of the previous winner
//   gnt  [NREQ-1:0]  one-hot grant (all zero when no request)
//   idx  [IW-1:0]    binary index of the granted requester (ptr when none)
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int  k;
        logic found;
        gnt   = '0;
        idx   = ptr;
        found = 1'b0;
        k     = 0;
        // Offsets 1..NREQ visit every requester once, ptr itself last.
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one bus between NREQ requesters with round-robin arbitration.
// Latency: req seen in IDLE -> SETUP next cycle -> ACCESS + o_done the cycle after; +1 per pready-low cycle.
// Backpressure: requesters hold i_req until o_done; slave stalls via pready, bounded by TIMEOUT.
//
// Ports:
//   pclk, presetn                 clock, async active-low reset
//   i_req/_write/_addr/_wdata/_strb  per-requester request bundle (packed, requester k at slot k)
//   o_done, o_rdata, o_err        one-cycle completion to the owning requester
//   o_psel .. o_pstrb             APB request side
//   i_prdata, i_pready, i_pslverr APB response side
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_req_write,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    input  logic [NREQ*DW-1:0]   i_req_wdata,
    input  logic [NREQ*DW/8-1:0] i_req_strb,
    output logic [NREQ-1:0]      o_done,
    output logic [DW-1:0]        o_rdata,
    output logic                 o_err,
    output logic                 o_psel,
    output logic                 o_penable,
    output logic                 o_pwrite,
    output logic [AW-1:0]        o_paddr,
    output logic [DW-1:0]        o_pwdata,
    output logic [DW/8-1:0]      o_pstrb,
    input  logic [DW-1:0]        i_prdata,
    input  logic                 i_pready,
    input  logic                 i_pslverr
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = DW / 8;

    generate
        if (NREQ < 2 || AW > APB_MAX_AW || DW > APB_MAX_DW ||
            (DW != 8 && DW != 16 && DW != 32)) begin : g_bad_param
            $error("apb_rr_master: unsupported NREQ/AW/DW combination");
        end
    endgenerate

    apb_state_t state, state_nxt;

    logic [IW-1:0]   rr_ptr;      // previous winner; also the owner of the transfer in flight
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            to_hit;
    logic            xfer_end;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (i_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // ACCESS ends on pready, or on the cycle the stall budget runs out.
    assign xfer_end = (state == ACCESS) && (i_pready || to_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|arb_gnt) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (xfer_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner's request is captured once at IDLE->SETUP; later changes on the
    // request inputs are ignored until the bus returns to IDLE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rr_ptr   <= IW'(NREQ - 1);
            o_pwrite <= 1'b0;
            o_paddr  <= '0;
            o_pwdata <= '0;
            o_pstrb  <= '0;
        end else if (state == IDLE && |arb_gnt) begin
            rr_ptr   <= arb_idx;
            o_pwrite <= i_req_write[arb_idx];
            o_paddr  <= i_req_addr[arb_idx*AW +: AW];
            o_pwdata <= i_req_wdata[arb_idx*DW +: DW];
            o_pstrb  <= i_req_write[arb_idx] ? i_req_strb[arb_idx*SW +: SW] : '0;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] to_cnt;

            // to_cnt holds the stalled ACCESS cycles already seen, so this cycle
            // is the TIMEOUT-th one when the count sits at TIMEOUT-1.
            assign to_hit = (state == ACCESS) && !i_pready && (to_cnt == CW'(TIMEOUT - 1));

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    to_cnt <= '0;
                end else if (state == SETUP) begin
                    to_cnt <= '0;
                end else if (state == ACCESS && !i_pready && !to_hit) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign to_hit = 1'b0;
        end
    endgenerate

    assign o_psel    = (state == SETUP) || (state == ACCESS);
    assign o_penable = (state == ACCESS);

    assign o_done  = xfer_end ? (NREQ'(1) << rr_ptr) : '0;
    assign o_rdata = (xfer_end && i_pready && !o_pwrite) ? i_prdata : '0;
    // pready in the same cycle as the timeout wins, so slverr is reported as-is.
    assign o_err   = xfer_end && (i_pready ? i_pslverr : 1'b1);

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        logic [4:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          gap;   // idle cycles before SETUP, -1 = not checked
    } exp_t;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic [NREQ-1:0]   i_req = '0;
    logic [NREQ-1:0]   i_req_write = '0;
    logic [AW-1:0]     req_addr  [NREQ];
    logic [DW-1:0]     req_wdata [NREQ];
    logic [DW/8-1:0]   req_strb  [NREQ];
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ*DW-1:0]   i_req_wdata;
    logic [NREQ*DW/8-1:0] i_req_strb;
    logic [NREQ-1:0]   o_done;
    logic [DW-1:0]     o_rdata;
    logic              o_err;
    logic              o_psel, o_penable, o_pwrite;
    logic [AW-1:0]     o_paddr;
    logic [DW-1:0]     o_pwdata;
    logic [DW/8-1:0]   o_pstrb;
    logic [DW-1:0]     i_prdata;
    logic              i_pready;
    logic              i_pslverr;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];

    // Slave model: answers after slave_wait stalled ACCESS cycles.
    int          slave_wait = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err = 1'b0;
    int          stall_cnt;

    assign i_req_addr  = {req_addr[1], req_addr[0]};
    assign i_req_wdata = {req_wdata[1], req_wdata[0]};
    assign i_req_strb  = {req_strb[1], req_strb[0]};
    assign i_pready    = o_penable && (stall_cnt >= slave_wait);
    assign i_prdata    = slave_rdata;
    assign i_pslverr   = slave_err;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn)                  stall_cnt <= 0;
        else if (o_penable && !i_pready) stall_cnt <= stall_cnt + 1;
        else                           stall_cnt <= 0;
    end

    always #5 pclk = ~pclk;

    apb_rr_master #(.NREQ(NREQ), .DW(DW), .AW(AW), .TIMEOUT(16)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .i_req       (i_req),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_strb  (i_req_strb),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_psel      (o_psel),
        .o_penable   (o_penable),
        .o_pwrite    (o_pwrite),
        .o_paddr     (o_paddr),
        .o_pwdata    (o_pwdata),
        .o_pstrb     (o_pstrb),
        .i_prdata    (i_prdata),
        .i_pready    (i_pready),
        .i_pslverr   (i_pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [31:0] rdata, input logic err,
                                input int acc, input logic [4:0] addr, input logic write,
                                input logic [31:0] wdata, input logic [3:0] strb, input int gap);
        exp_t e;
        e.idx = idx; e.rdata = rdata; e.err = err; e.acc = acc; e.addr = addr;
        e.write = write; e.wdata = wdata; e.strb = strb; e.gap = gap;
        return e;
    endfunction

    task automatic set_req(input int k, input logic wr, input logic [4:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        i_req_write[k] = wr;
        req_addr[k]    = addr;
        req_wdata[k]   = wdata;
        req_strb[k]    = strb;
    endtask

    // Requesters keep i_req high until they have seen n completions each.
    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_reqs(input int n0, input int n1, input int budget);
        int r0 = n0;
        int r1 = n1;
        int cyc = 0;
        i_req[0] = (r0 > 0);
        i_req[1] = (r1 > 0);
        while ((r0 > 0 || r1 > 0) && cyc < budget) begin
            @(negedge pclk);
            if (o_done[0]) r0--;
            if (o_done[1]) r1--;
            @(posedge pclk);
            #1;
            i_req[0] = (r0 > 0);
            i_req[1] = (r1 > 0);
            cyc++;
        end
        i_req = '0;
        if (r0 > 0 || r1 > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_reqs_budget: %0d/%0d completions missing after %0d cycles, expected 0/0", r0, r1, cyc);
        end
    endtask

    // Monitor: tracks each transfer on the bus and scores it at o_done.
    initial begin
        logic [4:0] setup_addr = '0;
        int         acc = 0;
        int         gap = 0;
        int         last_gap = 0;
        logic       stable = 1'b1;
        exp_t       e;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                acc = 0; gap = 0; stable = 1'b1;
            end else begin
                if (o_psel && !o_penable) begin
                    setup_addr = o_paddr;
                    acc        = 0;
                    stable     = 1'b1;
                    last_gap   = gap;
                end else if (!o_psel) begin
                    gap++;
                end
                if (o_psel && o_paddr !== setup_addr) stable = 1'b0;
                if (o_penable) acc++;
                if (o_done != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'(o_done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_onehot", 64'(o_done), 64'(2'b01 << e.idx));
                        chk("rdata", 64'(o_rdata), 64'(e.rdata));
                        chk("err", 64'(o_err), 64'(e.err));
                        chk("access_cycles", 64'(acc), 64'(e.acc));
                        chk("paddr", 64'(o_paddr), 64'(e.addr));
                        chk("paddr_stable", 64'(stable), 64'd1);
                        chk("pwrite", 64'(o_pwrite), 64'(e.write));
                        chk("pwdata", 64'(o_pwdata), 64'(e.wdata));
                        chk("pstrb", 64'(o_pstrb), 64'(e.strb));
                        if (e.gap >= 0) chk("idle_gap", 64'(last_gap), 64'(e.gap));
                    end
                    gap = 0;
                end
            end
        end
    end

    initial begin
        int cyc;
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k] = '0; req_wdata[k] = '0; req_strb[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", 64'(o_psel), 64'd0);
        chk("rst_penable", 64'(o_penable), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_paddr", 64'(o_paddr), 64'd0);
        chk("rst_pwdata", 64'(o_pwdata), 64'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // 1: single write, no wait states
        set_req(0, 1'b1, 5'h04, 32'hA5A5_0001, 4'hF);
        sb.push_back(mk(0, 32'h0, 1'b0, 1, 5'h04, 1'b1, 32'hA5A5_0001, 4'hF, -1));
        run_reqs(1, 0, 50);

        // 2: read with 3 wait states; strobes suppressed on reads
        set_req(1, 1'b0, 5'h0C, 32'h0000_0077, 4'hF);
        slave_wait = 3; slave_rdata = 32'hDEAD_BEEF;
        sb.push_back(mk(1, 32'hDEAD_BEEF, 1'b0, 4, 5'h0C, 1'b0, 32'h0000_0077, 4'h0, -1));
        run_reqs(0, 1, 50);

        // 3: both requesting continuously -> 0,1,0,1 with one idle cycle between
        slave_wait = 0; slave_rdata = 32'h1234_5678;
        set_req(0, 1'b1, 5'h10, 32'h1111_1111, 4'h3);
        set_req(1, 1'b0, 5'h14, 32'h2222_2222, 4'hC);
        sb.push_back(mk(0, 32'h0,         1'b0, 1, 5'h10, 1'b1, 32'h1111_1111, 4'h3, -1));
        sb.push_back(mk(1, 32'h1234_5678, 1'b0, 1, 5'h14, 1'b0, 32'h2222_2222, 4'h0, 1));
        sb.push_back(mk(0, 32'h0,         1'b0, 1, 5'h10, 1'b1, 32'h1111_1111, 4'h3, 1));
        sb.push_back(mk(1, 32'h1234_5678, 1'b0, 1, 5'h14, 1'b0, 32'h2222_2222, 4'h0, 1));
        run_reqs(2, 2, 100);

        // 4: slave error on a write, then a clean read with a wait state
        slave_err = 1'b1;
        set_req(0, 1'b1, 5'h0C, 32'h0BAD_0BAD, 4'h5);
        sb.push_back(mk(0, 32'h0, 1'b1, 1, 5'h0C, 1'b1, 32'h0BAD_0BAD, 4'h5, -1));
        run_reqs(1, 0, 50);
        slave_err = 1'b0; slave_wait = 1; slave_rdata = 32'h0000_00C3;
        set_req(1, 1'b0, 5'h08, 32'h0, 4'h0);
        sb.push_back(mk(1, 32'h0000_00C3, 1'b0, 2, 5'h08, 1'b0, 32'h0, 4'h0, -1));
        run_reqs(0, 1, 50);

        // 5: pready stuck low -> forced error on the 16th ACCESS cycle
        slave_wait = 1000; slave_rdata = 32'hCAFE_F00D;
        set_req(0, 1'b0, 5'h1C, 32'h0, 4'h0);
        sb.push_back(mk(0, 32'h0, 1'b1, 16, 5'h1C, 1'b0, 32'h0, 4'h0, -1));
        run_reqs(1, 0, 100);
        @(negedge pclk);
        chk("to_psel_after", 64'(o_psel), 64'd0);
        chk("to_penable_after", 64'(o_penable), 64'd0);
        @(posedge pclk); #1;

        // 6: reset during ACCESS, then req0 wins first again
        set_req(0, 1'b0, 5'h18, 32'h0, 4'h0);
        i_req[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
        end while (!o_penable && cyc < 20);
        chk("rst_mid_reached_access", 64'(o_penable), 64'd1);
        #2;
        presetn = 1'b0;
        i_req = '0;
        #1;
        chk("rst_mid_psel", 64'(o_psel), 64'd0);
        chk("rst_mid_penable", 64'(o_penable), 64'd0);
        chk("rst_mid_done", 64'(o_done), 64'd0);
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        slave_wait = 0; slave_rdata = 32'h5A5A_5A5A;
        set_req(0, 1'b1, 5'h02, 32'hAAAA_0000, 4'h1);
        set_req(1, 1'b0, 5'h03, 32'hBBBB_0000, 4'h2);
        @(posedge pclk); #1;
        sb.push_back(mk(0, 32'h0,         1'b0, 1, 5'h02, 1'b1, 32'hAAAA_0000, 4'h1, -1));
        sb.push_back(mk(1, 32'h5A5A_5A5A, 1'b0, 1, 5'h03, 1'b0, 32'hBBBB_0000, 4'h0, 1));
        run_reqs(1, 1, 50);

        repeat (3) @(posedge pclk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
